// File: rtl/sigmag_agc_pkg.sv
// ---------------------------------------------------------------------------
// sigmag_agc_pkg
//   Shared definitions for the sign/magnitude AGC block: FSM state codes,
//   register offsets, control struct and threshold helper.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`ifndef SIGMAG_AGC_ID_CONST
`define SIGMAG_AGC_ID_CONST 32'h5347_4101
`endif

`default_nettype none

package sigmag_agc_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  // Register bus geometry
  localparam int BUS_AW = 16;
  localparam int BUS_DW = 32;

  // Word offsets from BASEADDR; THR[k] at REG_THR0+k, LAST_CNT[k] at REG_THR0+NCH+k
  localparam logic [15:0] REG_ID   = 16'd0;
  localparam logic [15:0] REG_CFG  = 16'd1;
  localparam logic [15:0] REG_BAND = 16'd2;
  localparam logic [15:0] REG_STAT = 16'd3;
  localparam logic [15:0] REG_THR0 = 16'd4;

  // Decoded control bits of the CFG register
  typedef struct packed {
    logic freeze;
    logic en;
    logic restart;
  } sigmag_agc_ctrl_t;

  // Largest magnitude threshold representable for a given sample width
  function automatic int thr_max(input int in_w);
    return (1 << (in_w - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sigmag_agc_ch.sv
// ---------------------------------------------------------------------------
// sigmag_agc_ch
//   One channel: registered 2-bit sign/magnitude quantizer, per-window MAG
//   counter, magnitude threshold register and its step update rule.
//   Optional macro SIGMAG_AGC_STAT_EN keeps the last completed window count.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sigmag_agc_ch
  import sigmag_agc_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int WIN_LOG2 = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [IN_W-1:0]     raw_i,
  input  logic                idle_i,
  input  logic                inc_en_i,
  input  logic                update_i,
  input  logic                restart_i,
  input  logic                freeze_i,
  input  logic [IN_W-2:0]     step_i,
  input  logic [IN_W-2:0]     thr_init_i,
  input  logic [WIN_LOG2-1:0] tgt_lo_i,
  input  logic [WIN_LOG2-1:0] tgt_hi_i,
  output logic [1:0]          data_o,
  output logic [IN_W-2:0]     thr_o,
  output logic                in_band_o,
  output logic [WIN_LOG2:0]   last_cnt_o
);

  localparam logic [IN_W-2:0]   THR_MAX = (IN_W-1)'(thr_max(IN_W));
  localparam logic [WIN_LOG2:0] CNT_ONE = (WIN_LOG2+1)'(1);

  logic              sig_w;
  logic [IN_W-2:0]   abs_w;
  logic [IN_W-2:0]   thr_eff_w;
  logic              mag_w;
  logic [1:0]        data_d, data_q;
  logic [WIN_LOG2:0] cnt_d, cnt_q;
  logic [IN_W-2:0]   thr_d, thr_q;
  logic              in_band_d, in_band_q;
  logic [IN_W-1:0]   sum_w;
  logic [IN_W-2:0]   thr_up_w, thr_dn_w;
  logic              hi_w, lo_w;

  // Quantize the incoming sample; the idle loop tracks the programmed initial threshold directly
  always_comb begin
    sig_w     = raw_i[IN_W-1];
    abs_w     = sig_w ? ~raw_i[IN_W-2:0] : raw_i[IN_W-2:0];
    thr_eff_w = idle_i ? thr_init_i : thr_q;
    mag_w     = (abs_w > thr_eff_w);
    data_d    = {sig_w, mag_w};
  end

  // Count MAG decisions of samples arriving while a window is accumulating
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || idle_i || update_i) begin
      cnt_d = '0;
    end else if (inc_en_i && mag_w) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Saturating step candidates and band tests for the window just closed
  always_comb begin
    sum_w    = {1'b0, thr_q} + {1'b0, step_i};
    thr_up_w = sum_w[IN_W-1] ? THR_MAX : sum_w[IN_W-2:0];
    thr_dn_w = (thr_q < step_i) ? '0 : (thr_q - step_i);
    hi_w     = (cnt_q > {1'b0, tgt_hi_i});
    lo_w     = (cnt_q < {1'b0, tgt_lo_i});
  end

  // Threshold / band-status next state; restart dominates an update in the same cycle
  always_comb begin
    thr_d     = thr_q;
    in_band_d = in_band_q;
    if (restart_i) begin
      thr_d     = thr_init_i;
      in_band_d = 1'b0;
    end else if (idle_i) begin
      thr_d = thr_init_i;
    end else if (update_i) begin
      in_band_d = !hi_w && !lo_w;
      if (!freeze_i) begin
        if (hi_w) begin
          thr_d = thr_up_w;
        end else if (lo_w) begin
          thr_d = thr_dn_w;
        end
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q    <= '0;
      cnt_q     <= '0;
      thr_q     <= '0;
      in_band_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      thr_q     <= thr_d;
      in_band_q <= in_band_d;
    end
  end

  assign data_o    = data_q;
  assign thr_o     = thr_q;
  assign in_band_o = in_band_q;

`ifdef SIGMAG_AGC_STAT_EN
  logic [WIN_LOG2:0] last_cnt_q;

  // Hold the MAG count of the most recently completed window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_cnt_q <= '0;
    end else if (restart_i) begin
      last_cnt_q <= '0;
    end else if (update_i) begin
      last_cnt_q <= cnt_q;
    end
  end

  assign last_cnt_o = last_cnt_q;
`else
  assign last_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/sigmag_agc.sv
// ---------------------------------------------------------------------------
// sigmag_agc
//   Quantizes NCH raw ADC streams to {SIG,MAG} and closes a per-channel loop
//   on the magnitude threshold so the MAG duty per window stays in a band.
//   Register map (word offsets from BASEADDR):
//     0 ID, 1 CFG {THR_INIT,STEP,FREEZE,EN,RESTART(pulse)}, 2 BAND {TGT_HI,TGT_LO},
//     3 STAT {IN_BAND,WINS}, 4.. THR[k], 4+NCH.. LAST_CNT[k]
//   Optional macro SIGMAG_AGC_STAT_EN enables LAST_CNT storage (else reads 0).
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sigmag_agc
  import sigmag_agc_pkg::*;
#(
  parameter int BASEADDR = 0,
  parameter int NCH      = 2,
  parameter int IN_W     = 8,
  parameter int WIN_LOG2 = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NCH*IN_W-1:0] raw_i,
  output logic                adc_clk_o,
  output logic [2*NCH-1:0]    adc_data_o,
  input  logic [BUS_AW-1:0]   bus_addr_i,
  input  logic                bus_wr_i,
  input  logic [BUS_DW-1:0]   bus_wdata_i,
  output logic [BUS_DW-1:0]   bus_rdata_o
);

  localparam int                CFG_STEP_LSB = 3;
  localparam int                CFG_INIT_LSB = 3 + IN_W - 1;
  localparam logic [WIN_LOG2-1:0] WIN_ONE    = WIN_LOG2'(1);
  localparam logic [15:0]       WINS_ONE     = 16'd1;

  logic [BUS_AW-1:0]         offset_w;
  logic [BUS_DW-1:0]         cfg_q, band_q;
  logic                      restart_q;
  sigmag_agc_ctrl_t          ctrl_w;
  logic [IN_W-2:0]           step_w, thr_init_w;
  logic [WIN_LOG2-1:0]       tgt_lo_w, tgt_hi_w;
  logic [1:0]                state_d, state_q;
  logic [WIN_LOG2-1:0]       win_d, win_q;
  logic [15:0]               wins_d, wins_q;
  logic                      idle_w, accum_w, update_w;
  logic [NCH-1:0][IN_W-2:0]  thr_w;
  logic [NCH-1:0][WIN_LOG2:0] last_w;
  logic [NCH-1:0]            in_band_w;
  logic [BUS_DW-1:0]         rdata_w;

  assign offset_w = bus_addr_i - BUS_AW'(BASEADDR);

  // CPU-writable configuration; RESTART is a self-clearing pulse, never stored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q     <= '0;
      band_q    <= '0;
      restart_q <= 1'b0;
    end else begin
      restart_q <= bus_wr_i && (offset_w == REG_CFG) && bus_wdata_i[0];
      if (bus_wr_i && (offset_w == REG_CFG)) begin
        cfg_q <= {bus_wdata_i[BUS_DW-1:1], 1'b0};
      end
      if (bus_wr_i && (offset_w == REG_BAND)) begin
        band_q <= bus_wdata_i;
      end
    end
  end

  // Field extraction from the configuration words
  always_comb begin
    ctrl_w.restart = restart_q;
    ctrl_w.en      = cfg_q[1];
    ctrl_w.freeze  = cfg_q[2];
    step_w         = cfg_q[CFG_STEP_LSB +: IN_W-1];
    thr_init_w     = cfg_q[CFG_INIT_LSB +: IN_W-1];
    tgt_lo_w       = band_q[0 +: WIN_LOG2];
    tgt_hi_w       = band_q[WIN_LOG2 +: WIN_LOG2];
  end

  assign idle_w   = (state_q == ST_IDLE);
  assign accum_w  = (state_q == ST_ACCUM);
  assign update_w = (state_q == ST_UPDATE);

  // Window sequencing: IDLE -> ACCUM (2**WIN_LOG2 samples) -> UPDATE -> ACCUM ...
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wins_d  = wins_q;
    if (ctrl_w.restart) begin
      state_d = ctrl_w.en ? ST_ACCUM : ST_IDLE;
      win_d   = '0;
      wins_d  = '0;
    end else begin
      if (update_w) begin
        wins_d = wins_q + WINS_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          win_d   = '0;
          state_d = ctrl_w.en ? ST_ACCUM : ST_IDLE;
        end
        ST_ACCUM: begin
          win_d = win_q + WIN_ONE;
          if (!ctrl_w.en) begin
            state_d = ST_IDLE;
            win_d   = '0;
          end else if (win_q == '1) begin
            state_d = ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          win_d   = '0;
          state_d = ctrl_w.en ? ST_ACCUM : ST_IDLE;
        end
        default: begin
          win_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, window counter and window tally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      wins_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wins_q  <= wins_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    sigmag_agc_ch #(
      .IN_W     (IN_W),
      .WIN_LOG2 (WIN_LOG2)
    ) u_ch (
      .clk        (clk),
      .resetn     (resetn),
      .raw_i      (raw_i[k*IN_W +: IN_W]),
      .idle_i     (idle_w),
      .inc_en_i   (accum_w),
      .update_i   (update_w),
      .restart_i  (ctrl_w.restart),
      .freeze_i   (ctrl_w.freeze),
      .step_i     (step_w),
      .thr_init_i (thr_init_w),
      .tgt_lo_i   (tgt_lo_w),
      .tgt_hi_i   (tgt_hi_w),
      .data_o     (adc_data_o[2*k +: 2]),
      .thr_o      (thr_w[k]),
      .in_band_o  (in_band_w[k]),
      .last_cnt_o (last_w[k])
    );
  end

  assign adc_clk_o = clk;

  // Combinational register read-back
  always_comb begin
    rdata_w = '0;
    case (offset_w)
      REG_ID:   rdata_w = `SIGMAG_AGC_ID_CONST;
      REG_CFG:  rdata_w = cfg_q;
      REG_BAND: rdata_w = band_q;
      REG_STAT: begin
        rdata_w[15:0]     = wins_q;
        rdata_w[16 +: NCH] = in_band_w;
      end
      default: ;
    endcase
    for (int k = 0; k < NCH; k++) begin
      if (offset_w == REG_THR0 + BUS_AW'(k)) begin
        rdata_w[IN_W-2:0] = thr_w[k];
      end
      if (offset_w == REG_THR0 + BUS_AW'(NCH + k)) begin
        rdata_w[WIN_LOG2:0] = last_w[k];
      end
    end
  end

  assign bus_rdata_o = rdata_w;

endmodule

`default_nettype wire
